// File: rtl/alu_op_pkg.sv
// Shared decode constants and types for the ID/EX issue stage.
// ALUOP_* codes are also consumed by the EX-stage ALU.
package alu_op_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALUOP_NOP  = 4'b0000;
  localparam logic [3:0] ALUOP_ADD  = 4'b0001;
  localparam logic [3:0] ALUOP_SUB  = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_OR   = 4'b0100;
  localparam logic [3:0] ALUOP_MULT = 4'b0101;
  localparam logic [3:0] ALUOP_XOR  = 4'b0110;
  localparam logic [3:0] ALUOP_NOR  = 4'b0111;
  localparam logic [3:0] ALUOP_SLT  = 4'b1000;
  localparam logic [3:0] ALUOP_BEQ  = 4'b1001;
  localparam logic [3:0] ALUOP_JUMP = 4'b1010;
  localparam logic [3:0] ALUOP_LW   = 4'b1011;
  localparam logic [3:0] ALUOP_SW   = 4'b1100;
  localparam logic [3:0] ALUOP_ADDI = 4'b1101;

  typedef enum logic [1:0] {
    WREG_NONE = 2'd0,
    WREG_RD   = 2'd1,
    WREG_RT   = 2'd2
  } wreg_sel_e;

  typedef struct packed {
    logic [3:0] aluop;
    logic       use_imm;
    logic       uses_rt;
    wreg_sel_e  wreg_sel;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       illegal;
  } dec_ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decode into the issue-stage control struct.
module alu_op_decode
  import alu_op_pkg::*;
(
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    ctrl          = '0;
    ctrl.wreg_sel = WREG_NONE;
    case (op)
      OPC_RTYPE: begin
        ctrl.uses_rt = 1'b1;
        // Only the all-zero word is a NOP; other zero-funct encodings are illegal.
        if (instr != 32'd0) begin
          ctrl.regwrite = 1'b1;
          ctrl.wreg_sel = WREG_RD;
          case (fn)
            FN_ADD:  ctrl.aluop = ALUOP_ADD;
            FN_SUB:  ctrl.aluop = ALUOP_SUB;
            FN_AND:  ctrl.aluop = ALUOP_AND;
            FN_OR:   ctrl.aluop = ALUOP_OR;
            FN_MULT: ctrl.aluop = ALUOP_MULT;
            FN_XOR:  ctrl.aluop = ALUOP_XOR;
            FN_NOR:  ctrl.aluop = ALUOP_NOR;
            FN_SLT:  ctrl.aluop = ALUOP_SLT;
            default: begin
              ctrl.illegal  = 1'b1;
              ctrl.regwrite = 1'b0;
              ctrl.wreg_sel = WREG_NONE;
            end
          endcase
        end
      end
      OPC_LW: begin
        ctrl.aluop    = ALUOP_LW;
        ctrl.use_imm  = 1'b1;
        ctrl.wreg_sel = WREG_RT;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
      end
      OPC_SW: begin
        ctrl.aluop    = ALUOP_SW;
        ctrl.use_imm  = 1'b1;
        ctrl.uses_rt  = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OPC_ADDI: begin
        ctrl.aluop    = ALUOP_ADDI;
        ctrl.use_imm  = 1'b1;
        ctrl.wreg_sel = WREG_RT;
        ctrl.regwrite = 1'b1;
      end
      OPC_BEQ: begin
        ctrl.aluop   = ALUOP_BEQ;
        ctrl.uses_rt = 1'b1;
      end
      OPC_J:   ctrl.aluop = ALUOP_JUMP;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decode, operand select, load-use bubble FSM and ID/EX register.
// Optional counters enabled by defining ALU_OP_ISSUE_STATS_EN.
module alu_op_issue
  import alu_op_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          ex_ready,
  input  logic          flush,
  output logic          ex_valid,
  output logic [3:0]    ex_aluop,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [RW-1:0] ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_illegal,
  output logic          dbg_state
`ifdef ALU_OP_ISSUE_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_bubbles,
  output logic [31:0]   stat_illegal
`endif
);

  // Handshake: an ID word moves into ID/EX on the edge where in_valid & in_ready;
  // the ID/EX entry is consumed on the edge where ex_valid & ex_ready.
  dec_ctrl_t    dec;
  issue_state_e state_q;
  logic         ex_valid_q, regwrite_q, memread_q, memwrite_q, illegal_q;
  logic [3:0]   aluop_q;
  logic [DW-1:0] a_q, b_q, a_d, b_d;
  logic [RW-1:0] wreg_q, wreg_d, rs_idx, rt_idx, rd_idx;
  logic         advance, hazard, transfer;

  alu_op_decode u_dec (
    .instr (instr),
    .ctrl  (dec)
  );

  assign rs_idx = RW'(instr[25:21]);
  assign rt_idx = RW'(instr[20:16]);
  assign rd_idx = RW'(instr[15:11]);

  assign advance  = ~ex_valid_q | ex_ready;
  assign hazard   = ex_valid_q & memread_q & (wreg_q != '0) &
                    ((wreg_q == rs_idx) | ((wreg_q == rt_idx) & dec.uses_rt));
  assign in_ready = rst_n & ~flush & advance & ~hazard & (state_q == ST_RUN);
  assign transfer = in_valid & in_ready;

  always_comb begin
    a_d = rs_data;
    b_d = rt_data;
    if (dec.use_imm) b_d = {{(DW-16){instr[15]}}, instr[15:0]};
    if (dec.aluop == ALUOP_JUMP) begin
      a_d = '0;
      b_d = '0;
    end
    case (dec.wreg_sel)
      WREG_RD: wreg_d = rd_idx;
      WREG_RT: wreg_d = rt_idx;
      default: wreg_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      aluop_q    <= ALUOP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      aluop_q    <= ALUOP_NOP;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (advance) begin
            ex_valid_q <= transfer;
            if (transfer) begin
              aluop_q    <= dec.aluop;
              a_q        <= a_d;
              b_q        <= b_d;
              wreg_q     <= wreg_d;
              regwrite_q <= dec.regwrite;
              memread_q  <= dec.memread;
              memwrite_q <= dec.memwrite;
              illegal_q  <= dec.illegal;
            end
            if (hazard && in_valid) state_q <= ST_BUBBLE;
          end
        end
        ST_BUBBLE: begin
          // Second bubble cycle; wait here while EX is stalled.
          ex_valid_q <= 1'b0;
          if (ex_ready) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_aluop    = aluop_q;
  assign ex_a        = a_q;
  assign ex_b        = b_q;
  assign ex_wreg     = wreg_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_memwrite = memwrite_q;
  assign ex_illegal  = illegal_q;
  assign dbg_state   = (state_q == ST_BUBBLE);

`ifdef ALU_OP_ISSUE_STATS_EN
  logic        bubble_evt;
  logic [31:0] issued_q, bubbles_q, illegal_cnt_q;

  assign bubble_evt = (state_q == ST_RUN) & ~flush & advance & hazard & in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q      <= '0;
      bubbles_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (transfer) issued_q <= issued_q + 32'd1;
      if (transfer && dec.illegal) illegal_cnt_q <= illegal_cnt_q + 32'd1;
      if (bubble_evt) bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign stat_issued  = issued_q;
  assign stat_bubbles = bubbles_q;
  assign stat_illegal = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Randomized scoreboard bench for alu_op_issue with an instruction-level reference model.
module tb_alu_op_issue;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          ex_ready = 1'b0;
  logic          flush = 1'b0;
  logic [31:0]   instr = '0;
  logic [DW-1:0] rs_data = '0;
  logic [DW-1:0] rt_data = '0;
  logic          in_ready, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal, dbg_state;
  logic [3:0]    ex_aluop;
  logic [DW-1:0] ex_a, ex_b;
  logic [RW-1:0] ex_wreg;
`ifdef ALU_OP_ISSUE_STATS_EN
  logic [31:0]   stat_issued, stat_bubbles, stat_illegal;
`endif

  always #5 clk = ~clk;

  alu_op_issue #(.DW(DW), .RW(RW)) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .instr (instr), .rs_data (rs_data), .rt_data (rt_data), .ex_ready (ex_ready),
    .flush (flush), .ex_valid (ex_valid), .ex_aluop (ex_aluop), .ex_a (ex_a),
    .ex_b (ex_b), .ex_wreg (ex_wreg), .ex_regwrite (ex_regwrite),
    .ex_memread (ex_memread), .ex_memwrite (ex_memwrite), .ex_illegal (ex_illegal),
    .dbg_state (dbg_state)
`ifdef ALU_OP_ISSUE_STATS_EN
    , .stat_issued (stat_issued), .stat_bubbles (stat_bubbles), .stat_illegal (stat_illegal)
`endif
  );

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        illegal;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   m_occ = 1'b0;
  bit   m_bub = 1'b0;
  exp_t m_rec = '0;
  int   n_xfer = 0, n_ill = 0, n_bub = 0;

  localparam logic [31:0] I_ADD  = 32'h0109_5020;  // add $t2,$t0,$t1
  localparam logic [31:0] I_ADDI = 32'h2128_FFFF;  // addi $t0,$t1,-1
  localparam logic [31:0] I_LW   = 32'h8E08_0004;  // lw $t0,4($s0)
  localparam logic [31:0] I_SW   = 32'hAE09_0008;  // sw $t1,8($s0)
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;  // opcode 111111

  task automatic chk(input string nm, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit uses_rt(input logic [31:0] ins);
    return ins[31:26] == 6'h00 || ins[31:26] == 6'h2b || ins[31:26] == 6'h04;
  endfunction

  // What the EX stage should see for an instruction, straight from the ISA table.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    e = '0;
    e.a = rs;
    e.b = rt;
    if (ins == 32'd0) begin
      e.aluop = 4'd0;
    end else if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: e.aluop = 4'd1;
        6'h22: e.aluop = 4'd2;
        6'h24: e.aluop = 4'd3;
        6'h25: e.aluop = 4'd4;
        6'h18: e.aluop = 4'd5;
        6'h26: e.aluop = 4'd6;
        6'h27: e.aluop = 4'd7;
        6'h2a: e.aluop = 4'd8;
        default: e.illegal = 1'b1;
      endcase
      if (!e.illegal) begin
        e.regwrite = 1'b1;
        e.wreg = ins[15:11];
      end
    end else begin
      case (ins[31:26])
        6'h23: begin e.aluop = 4'd11; e.b = 32'($signed(ins[15:0])); e.wreg = ins[20:16]; e.regwrite = 1'b1; e.memread = 1'b1; end
        6'h2b: begin e.aluop = 4'd12; e.b = 32'($signed(ins[15:0])); e.memwrite = 1'b1; end
        6'h08: begin e.aluop = 4'd13; e.b = 32'($signed(ins[15:0])); e.wreg = ins[20:16]; e.regwrite = 1'b1; end
        6'h04: e.aluop = 4'd9;
        6'h02: begin e.aluop = 4'd10; e.a = '0; e.b = '0; end
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [5:0] rand_fn();
    case ($urandom_range(0, 8))
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      4: return 6'h18;
      5: return 6'h26;
      6: return 6'h27;
      7: return 6'h2a;
      default: return 6'h3f;
    endcase
  endfunction

  // Small register range so load-use collisions happen often.
  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, rand_fn()};
      3:       return {6'h23, rs, rt, imm};
      4:       return {6'h2b, rs, rt, imm};
      5:       return {6'h08, rs, rt, imm};
      6:       return {6'h04, rs, rt, imm};
      7:       return {6'h02, 26'($urandom)};
      8:       return 32'd0;
      default: return {6'($urandom_range(48, 63)), 26'($urandom)};
    endcase
  endfunction

  // One cycle: drive at negedge, check in_ready/ex_valid/state, push accepted
  // instructions, then advance the occupancy model to the coming edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic er, input logic fl);
    logic adv, haz, rdy, xfer;
    exp_t e;
    @(negedge clk);
    rst_n = r; in_valid = v; instr = ins; rs_data = rs; rt_data = rt; ex_ready = er; flush = fl;
    #1;
    adv  = !m_occ || er;
    haz  = m_occ && m_rec.memread && (m_rec.wreg != 5'd0) &&
           (m_rec.wreg == ins[25:21] || (m_rec.wreg == ins[20:16] && uses_rt(ins)));
    rdy  = r && !fl && adv && !haz && !m_bub;
    chk("in_ready", EW'(in_ready), EW'(rdy));
    chk("ex_valid", EW'(ex_valid), EW'(m_occ));
    chk("dbg_state", EW'(dbg_state), EW'(m_bub));
    xfer = v && rdy;
    e = ref_decode(ins, rs, rt);
    if (xfer) exp_q.push_back(e);
    #2;
    if (!r) begin
      exp_q.delete();
      m_occ = 1'b0; m_bub = 1'b0;
      n_xfer = 0; n_ill = 0; n_bub = 0;
    end else if (fl) begin
      if (m_occ && exp_q.size() > 0) void'(exp_q.pop_front());
      m_occ = 1'b0; m_bub = 1'b0;
    end else if (m_bub) begin
      if (er) m_bub = 1'b0;
    end else if (adv) begin
      m_occ = xfer;
      if (xfer) begin
        m_rec = e;
        n_xfer++;
        if (e.illegal) n_ill++;
      end
      if (haz && v) begin
        m_bub = 1'b1;
        n_bub++;
      end
    end
  endtask

  // Monitor: whenever EX holds an entry it must match the oldest expected one.
  initial begin
    exp_t g;
    forever begin
      @(negedge clk);
      #2;
      if (ex_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got ex_valid=1 aluop=%h a=%h, expected no entry", ex_aluop, ex_a);
        end else begin
          g.aluop = ex_aluop; g.a = ex_a; g.b = ex_b; g.wreg = ex_wreg;
          g.regwrite = ex_regwrite; g.memread = ex_memread;
          g.memwrite = ex_memwrite; g.illegal = ex_illegal;
          chk("ex_entry", g, exp_q[0]);
          if (ex_ready && !flush && rst_n) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    step(0, 0, 32'd0, 0, 0, 0, 0);
    step(0, 1, I_ADD, 1, 2, 1, 0);
    chk("rst_aluop", EW'(ex_aluop), EW'(0));
    chk("rst_ab", EW'({ex_a, ex_b}), EW'(0));
    chk("rst_ctrl", EW'({ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_illegal}), EW'(0));

    step(1, 1, I_ADD, 5, 7, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);
    step(1, 1, I_ADDI, 3, 9, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);

    // Load-use: lw then dependent add.
    step(1, 1, I_LW, 100, 0, 1, 0);
    repeat (3) step(1, 1, I_ADD, 1, 2, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);

    // Stall with a store held in EX.
    step(1, 1, I_SW, 40, 41, 1, 0);
    repeat (3) step(1, 1, I_ADD, 11, 12, 0, 0);
    step(1, 1, I_ADD, 11, 12, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);

    // Flush while in BUBBLE, then the add must issue exactly once.
    step(1, 1, I_LW, 7, 0, 1, 0);
    step(1, 1, I_ADD, 3, 4, 1, 0);
    step(1, 1, I_ADD, 3, 4, 1, 1);
    step(1, 1, I_ADD, 3, 4, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);

    step(1, 1, I_ILL, 9, 9, 1, 0);
    step(1, 0, 32'd0, 0, 0, 1, 0);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 7), rand_instr(),
           $urandom, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
    end

    repeat (4) step(1, 0, 32'd0, 0, 0, 1, 0);
    chk("drain", EW'(exp_q.size()), EW'(0));
`ifdef ALU_OP_ISSUE_STATS_EN
    chk("stat_issued", EW'(stat_issued), EW'(n_xfer));
    chk("stat_illegal", EW'(stat_illegal), EW'(n_ill));
    chk("stat_bubbles", EW'(stat_bubbles), EW'(n_bub));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
